// File: rtl/rv32_lsu_mem_port.sv
// rv32_lsu_mem_port
// Bridges the RV32I load/store unit to a single-beat request/acknowledge
// memory port. One access is in flight at a time. The access is checked for
// a legal width code and natural alignment. Legal accesses are then issued as
// a word-addressed request with byte-lane enables. Load data is extracted from
// the returned word, then sign- or zero-extended.
//
// Handshake: in IDLE, a cycle with load or store high is a request and it is
// accepted on that edge. mem_req then stays high, with address, direction,
// byte enables and write data stable, until the first edge at which mem_ack
// is high (completion), or until TIMEOUT request cycles pass without mem_ack
// (abort). mem_ack outside the request phase is ignored.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   load, store         core access request (sampled only in IDLE)
//   funct3              RV32I width/sign code
//   data_addr_bus       effective byte address
//   store_data          rs2 value for stores
//   data_reg_d1         aligned, extended result of the last successful load
//   lsu_busy            access in flight (REQ, DONE or ERR)
//   lsu_done / lsu_err  one-cycle completion / rejection-or-abort pulses
//   mem_req .. mem_wdata memory request side
//   mem_rdata, mem_ack  memory response side
//   dbg_state_o         current FSM state for observation
module rv32_lsu_mem_port #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [31:0] data_addr_bus,
    input  logic [31:0] store_data,
    output logic [31:0] data_reg_d1,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic        lsu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // Counter value seen in the last REQ cycle before the access is aborted.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] sdata_q, sdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_legal;
    logic        in_req;
    logic [3:0]  be_lanes;
    logic [31:0] wdata_lanes;
    logic [31:0] rd_shift;
    logic [31:0] load_result;

    // Width code and natural-alignment check on the live request inputs.
    always_comb begin
        req_legal = 1'b0;
        case (funct3)
            3'b000:  req_legal = 1'b1;
            3'b001:  req_legal = ~data_addr_bus[0];
            3'b010:  req_legal = (data_addr_bus[1:0] == 2'b00);
            3'b100:  req_legal = load;
            3'b101:  req_legal = load & ~data_addr_bus[0];
            default: req_legal = 1'b0;
        endcase
        if (load && store) begin
            req_legal = 1'b0;
        end
    end

    // Lane mask and replicated store data from the registered access.
    always_comb begin
        be_lanes    = 4'b1111;
        wdata_lanes = sdata_q;
        case (f3_q[1:0])
            2'b00: begin
                be_lanes    = 4'b0001 << addr_q[1:0];
                wdata_lanes = {4{sdata_q[7:0]}};
            end
            2'b01: begin
                be_lanes    = 4'b0011 << {addr_q[1], 1'b0};
                wdata_lanes = {2{sdata_q[15:0]}};
            end
            default: begin
                be_lanes    = 4'b1111;
                wdata_lanes = sdata_q;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0. A legal halfword has addr[0]=0,
    // so shifting by the full byte offset also selects the right half.
    assign rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_result = mem_rdata;
        case (f3_q)
            3'b000:  load_result = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  load_result = {24'd0, rd_shift[7:0]};
            3'b001:  load_result = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  load_result = {16'd0, rd_shift[15:0]};
            default: load_result = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        f3_d    = f3_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (load || store) begin
                    addr_d  = data_addr_bus;
                    sdata_d = store_data;
                    f3_d    = funct3;
                    we_d    = store;
                    cnt_d   = 8'd0;
                    state_d = req_legal ? S_REQ : S_ERR;
                end
            end
            S_REQ: begin
                // An ack always wins over an expiring counter.
                if (mem_ack) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        rdata_d = load_result;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            sdata_q <= 32'd0;
            f3_q    <= 3'd0;
            we_q    <= 1'b0;
            cnt_q   <= 8'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Request outputs decode straight from the state register, so an
    // asynchronous reset removes mem_req in the same cycle.
    assign in_req      = (state_q == S_REQ);
    assign mem_req     = in_req;
    assign mem_we      = in_req & we_q;
    assign mem_addr    = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_be      = in_req ? be_lanes : 4'd0;
    assign mem_wdata   = (in_req && we_q) ? wdata_lanes : 32'd0;
    assign data_reg_d1 = rdata_q;
    assign lsu_busy    = (state_q != S_IDLE);
    assign lsu_done    = (state_q == S_DONE);
    assign lsu_err     = (state_q == S_ERR);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rv32_lsu_mem_port.sv
// tb_rv32_lsu_mem_port
// Directed plus randomized bench for rv32_lsu_mem_port with TIMEOUT=4.
// Expected request fields and load results come from a byte-arithmetic
// reference model. Completed load results pass through an expected queue.
module tb_rv32_lsu_mem_port;

    localparam int TIMEOUT = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        load = 1'b0;
    logic        store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] data_addr_bus = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [31:0] data_reg_d1;
    logic        lsu_busy, lsu_done, lsu_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic [1:0]  dbg_state;

    rv32_lsu_mem_port #(.TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load),
        .store         (store),
        .funct3        (funct3),
        .data_addr_bus (data_addr_bus),
        .store_data    (store_data),
        .data_reg_d1   (data_reg_d1),
        .lsu_busy      (lsu_busy),
        .lsu_done      (lsu_done),
        .lsu_err       (lsu_err),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .dbg_state_o   (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_data = 32'd0;
    logic [31:0] exp_q[$];

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned ref_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit ref_legal(input bit ld, input bit st, input logic [2:0] f3,
                                     input logic [31:0] a);
        if (ld && st) return 1'b0;
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
        return (a % ref_bytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned mask;
        mask = (1 << ref_bytes(f3)) - 1;
        return 4'(mask << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input bit st, input logic [2:0] f3,
                                              input logic [31:0] sd);
        if (!st) return 32'd0;
        case (ref_bytes(f3))
            1:       return (sd & 32'hFF) * 32'h0101_0101;
            2:       return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        int unsigned bits;
        logic [31:0] v;
        bits = 8 * ref_bytes(f3);
        if (bits == 32) return rd;
        v = (rd >> (8 * (a % 4))) & ((32'd1 << bits) - 32'd1);
        if (f3[2] == 1'b0 && ((v >> (bits - 1)) & 32'd1) == 32'd1)
            v = v - (32'd1 << bits);
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    // Present one request for a cycle and follow it to completion.
    // ack_delay = index of the REQ cycle carrying mem_ack (>= TIMEOUT: never).
    // poke = raise load/store at random while the access is in flight.
    task automatic do_access(input bit ld, input bit st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd,
                             input int ack_delay, input logic [31:0] rd, input bit poke);
        bit ok;
        logic [31:0] exp_v;
        ok = ref_legal(ld, st, f3, a);
        load = ld; store = st; funct3 = f3; data_addr_bus = a; store_data = sd;
        @(negedge clk);
        load = 1'b0; store = 1'b0;
        funct3 = 3'($urandom); data_addr_bus = $urandom; store_data = $urandom;
        if (!ok) begin
            check32("rej_err", 32'(lsu_err), 32'd1);
            check32("rej_done", 32'(lsu_done), 32'd0);
            check32("rej_req", 32'(mem_req), 32'd0);
            check32("rej_busy", 32'(lsu_busy), 32'd1);
            check32("rej_data", data_reg_d1, model_data);
        end else begin
            for (int c = 0; c < TIMEOUT; c++) begin
                check32("req_req", 32'(mem_req), 32'd1);
                check32("req_addr", mem_addr, {a[31:2], 2'b00});
                check32("req_we", 32'(mem_we), 32'(st));
                check32("req_be", 32'(mem_be), 32'(ref_be(f3, a)));
                check32("req_wdata", mem_wdata, ref_wdata(st, f3, sd));
                check32("req_busy", 32'(lsu_busy), 32'd1);
                check32("req_pulse", {30'd0, lsu_done, lsu_err}, 32'd0);
                mem_ack = (c == ack_delay);
                mem_rdata = (c == ack_delay) ? rd : $urandom;
                if (poke) begin
                    load = 1'($urandom_range(0, 1));
                    store = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                mem_ack = 1'b0; load = 1'b0; store = 1'b0; mem_rdata = $urandom;
                if (c == ack_delay) break;
            end
            if (ack_delay < TIMEOUT) begin
                check32("fin_done", 32'(lsu_done), 32'd1);
                check32("fin_err", 32'(lsu_err), 32'd0);
                if (ld) begin
                    exp_q.push_back(ref_load(f3, a, rd));
                    model_data = ref_load(f3, a, rd);
                end
            end else begin
                check32("tmo_err", 32'(lsu_err), 32'd1);
                check32("tmo_done", 32'(lsu_done), 32'd0);
            end
            check32("fin_req", 32'(mem_req), 32'd0);
            check32("fin_busy", 32'(lsu_busy), 32'd1);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                check32("load_data", data_reg_d1, exp_v);
            end else begin
                check32("data_hold", data_reg_d1, model_data);
            end
        end
        @(negedge clk);
        check32("idle_busy", 32'(lsu_busy), 32'd0);
        check32("idle_pulse", {30'd0, lsu_done, lsu_err}, 32'd0);
        check32("idle_req", 32'(mem_req), 32'd0);
        check32("idle_data", data_reg_d1, model_data);
    endtask

    task automatic check_all_zero(input string tag);
        check32({tag, "_data"}, data_reg_d1, 32'd0);
        check32({tag, "_ctl"}, {26'd0, lsu_busy, lsu_done, lsu_err, mem_req, mem_we, 1'b0}, 32'd0);
        check32({tag, "_addr"}, mem_addr, 32'd0);
        check32({tag, "_be"}, 32'(mem_be), 32'd0);
        check32({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bit          ld, st;
        int          r;

        // Reset state
        #2;
        check_all_zero("rst_hold");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("rst_rel");
        check32("rst_state", 32'(dbg_state), 32'd0);

        // LB 0x103, ack in first REQ cycle: lane 3, sign-extended 0x80
        do_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h80FF_FFFF, 1'b0);
        check32("lb_result", data_reg_d1, 32'hFFFF_FF80);

        // SH 0x202, ack after 3 wait cycles (last cycle before timeout: ack wins)
        do_access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 3, 32'h5555_5555, 1'b0);
        check32("sh_data_hold", data_reg_d1, 32'hFFFF_FF80);

        // Misaligned LW rejected; LHU upper half zero-extended
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0301, 32'h0, 0, 32'h0, 1'b0);
        do_access(1'b1, 1'b0, 3'b101, 32'h0000_0302, 32'h0, 1, 32'h9ABC_0000, 1'b0);
        check32("lhu_result", data_reg_d1, 32'h0000_9ABC);

        // Load that never sees an ack times out; load acked on the 4th cycle succeeds
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 99, 32'h0, 1'b0);
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0404, 32'h0, 3, 32'hCAFE_F00D, 1'b0);

        // Simultaneous load+store rejected; new requests during REQ ignored
        do_access(1'b1, 1'b1, 3'b000, 32'h0000_0500, 32'h0, 0, 32'h0, 1'b0);
        do_access(1'b1, 1'b0, 3'b100, 32'h0000_0601, 32'h0, 2, 32'h0000_F700, 1'b1);

        // mem_ack outside REQ has no effect
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        check32("stray_ack_busy", 32'(lsu_busy), 32'd0);
        check32("stray_ack_data", data_reg_d1, model_data);
        mem_ack = 1'b0;

        // Randomized accesses
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            ld = (r < 5) || (r == 9);
            st = (r >= 5);
            do_access(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom,
                      $urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a request
        load = 1'b1; funct3 = 3'b010; data_addr_bus = 32'h0000_0800;
        @(negedge clk);
        load = 1'b0;
        check32("mid_req_up", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_data = 32'd0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check32("post_rst_quiet", {29'd0, lsu_busy, lsu_done, lsu_err}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
